// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: manual modes, FSM states, transfer direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

    // Manual operation codes on the mode port; codes 6 and 7 are reserved and behave as HOLD.
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Automatic transfer direction, sampled together with start.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bits needed to count shift positions 0..w-1; never less than one bit.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Shift-position counter for automatic transfers; tc flags the last position (WIDTH-1).
// Latency: count updates on each falling clk edge; tc is combinational from the count.
// Backpressure: none; saturates at WIDTH-1 instead of wrapping.
//
// Ports: clk (falling-edge), reset (async active-low), clr (sync clear, wins over en),
//        en (advance one position), tc (count == WIDTH-1).
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == LAST);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: manual hold/load/shift/rotate plus an automatic WIDTH-bit transfer FSM.
// Latency: one falling clk edge per operation; a transfer takes 1 load edge + WIDTH shift edges + 1 done edge.
// Backpressure: none; start and mode are ignored while busy or done (no queuing of requests).
//
// Ports: clk (all state on falling edge), reset (async active-low), mode (manual op), pi (parallel data),
//        sil/sir (serial fill for left/right shifts), start/dir (launch transfer, dir 0 left / 1 right),
//        po (register contents), so_l/so_r (po MSB/LSB), busy (in SHIFT), done (one-cycle completion pulse).
// Build option: define SHIFT_ROTATE_EN to enable ROL/ROR; otherwise those codes hold.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pi,
    input  logic             sil,
    input  logic             sir,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] po,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    state_e           state;
    logic             dir_q;
    logic             tc;
    logic [WIDTH-1:0] po_shl;
    logic [WIDTH-1:0] po_shr;
    logic [WIDTH-1:0] po_manual;

    assign so_l = po[WIDTH-1];
    assign so_r = po[0];

    assign po_shl = {po[WIDTH-2:0], sil};
    assign po_shr = {sir, po[WIDTH-1:1]};

    // Next value for the manual (IDLE, no start) path.
    always_comb begin
        po_manual = po;
        case (mode)
            MODE_LOAD: po_manual = pi;
            MODE_SHL:  po_manual = po_shl;
            MODE_SHR:  po_manual = po_shr;
`ifdef SHIFT_ROTATE_EN
            MODE_ROL:  po_manual = {po[WIDTH-2:0], po[WIDTH-1]};
            MODE_ROR:  po_manual = {po[0], po[WIDTH-1:1]};
`endif
            default:   po_manual = po;
        endcase
    end

    // The counter is cleared on the load edge and advances on each shift edge, so tc marks the
    // WIDTH-th shift: exactly WIDTH shift edges happen before the FSM leaves SHIFT.
    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state == ST_IDLE) && start),
        .en    (state == ST_SHIFT),
        .tc    (tc)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            po    <= '0;
            state <= ST_IDLE;
            dir_q <= DIR_LEFT;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        po    <= pi;
                        dir_q <= dir;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        po <= po_manual;
                    end
                end
                ST_SHIFT: begin
                    po <= (dir_q == DIR_RIGHT) ? po_shr : po_shl;
                    if (tc) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): reference model plus directed literal checks.
// Latency: model tracks the DUT edge for edge; outputs compared on every rising clk edge.
// Backpressure: n/a.
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b1;
    logic         reset = 1'b0;
    logic [2:0]   mode = '0;
    logic [W-1:0] pi = '0;
    logic         sil = 1'b0;
    logic         sir = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] po;
    logic         so_l;
    logic         so_r;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .pi    (pi),
        .sil   (sil),
        .sir   (sir),
        .start (start),
        .dir   (dir),
        .po    (po),
        .so_l  (so_l),
        .so_r  (so_r),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is "remaining shifts" plus a done flag; manual modes as arithmetic.
    logic [W-1:0] m_po   = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dir  = 1'b0;
    int           m_rem  = 0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            m_po = '0; m_busy = 1'b0; m_done = 1'b0; m_dir = 1'b0; m_rem = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            if (m_dir) m_po = (m_po >> 1) | (W'(sir) << (W - 1));
            else       m_po = (m_po << 1) | W'(sil);
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            m_po = pi; m_dir = dir; m_rem = W; m_busy = 1'b1;
        end else begin
            case (mode)
                3'd1: m_po = pi;
                3'd2: m_po = (m_po << 1) | W'(sil);
                3'd3: m_po = (m_po >> 1) | (W'(sir) << (W - 1));
`ifdef SHIFT_ROTATE_EN
                3'd4: m_po = (m_po << 1) | (m_po >> (W - 1));
                3'd5: m_po = (m_po >> 1) | (m_po << (W - 1));
`endif
                default: m_po = m_po;
            endcase
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            chk("po",   po,   m_po);
            chk("so_l", so_l, m_po[W-1]);
            chk("so_r", so_r, m_po[0]);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
        end
    end

    // Apply one set of inputs for exactly one falling edge; returns just after the next rising edge.
    task automatic step(input logic [2:0] md, input logic [W-1:0] p, input logic l, input logic r,
                        input logic s, input logic d);
        mode = md; pi = p; sil = l; sir = r; start = s; dir = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_sol;
        int         busy_cnt;

        // Reset state.
        #12;
        chk("rst_po", po, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Manual modes.
        step(MODE_LOAD, 8'hA5, 0, 0, 0, 0); chk("load_a5", po, 8'hA5);
        step(MODE_SHL,  8'h00, 1, 0, 0, 0); chk("shl",     po, 8'h4B);
        step(MODE_LOAD, 8'hA5, 0, 0, 0, 0);
        step(MODE_SHR,  8'h00, 0, 0, 0, 0); chk("shr",     po, 8'h52);
        step(3'd7,      8'hFF, 1, 1, 0, 0); chk("mode7",   po, 8'h52);
        step(3'd6,      8'hFF, 1, 1, 0, 0); chk("mode6",   po, 8'h52);

        // Rotates.
        step(MODE_LOAD, 8'h81, 0, 0, 0, 0);
        step(MODE_ROL,  8'h00, 0, 0, 0, 0);
`ifdef SHIFT_ROTATE_EN
        chk("rol", po, 8'h03);
`else
        chk("rol", po, 8'h81);
`endif
        step(MODE_LOAD, 8'h81, 0, 0, 0, 0);
        step(MODE_ROR,  8'h00, 1, 1, 0, 0);
`ifdef SHIFT_ROTATE_EN
        chk("ror", po, 8'hC0);
`else
        chk("ror", po, 8'h81);
`endif

        // Left transfer of 0x81 with zero fill.
        exp_sol = 8'b1000_0001;
        busy_cnt = 0;
        step(MODE_HOLD, 8'h81, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            busy_cnt += int'(busy);
            chk("xfer_l_so_l", so_l, exp_sol[i]);
            step(MODE_HOLD, 8'h00, 0, 0, 0, 0);
        end
        busy_cnt += int'(busy);
        chk("xfer_l_po", po, 8'h00);
        chk("xfer_l_done", done, 1'b1);
        chk("xfer_l_busycnt", busy_cnt, 8);
        step(MODE_HOLD, 8'h00, 0, 0, 0, 0);
        chk("xfer_l_done_end", done, 1'b0);

        // Right transfer with one fill; start and mode pokes during SHIFT and DONE are ignored.
        step(MODE_HOLD, 8'h01, 0, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            step(MODE_LOAD, 8'h00, 0, 1, (i == 2 || i == 5), 0);
        end
        chk("xfer_r_po", po, 8'hFF);
        chk("xfer_r_done", done, 1'b1);
        step(MODE_LOAD, 8'h00, 0, 1, 1, 0);
        chk("xfer_r_ign_busy", busy, 1'b0);
        chk("xfer_r_ign_po", po, 8'hFF);
        step(MODE_HOLD, 8'h00, 0, 0, 0, 0);
        chk("xfer_r_idle_busy", busy, 1'b0);

        // Asynchronous reset with po=0x5A, checked before the next falling edge.
        step(MODE_LOAD, 8'h5A, 0, 0, 0, 0);
        chk("pre_rst_po", po, 8'h5A);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_po", po, 8'h00);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(MODE_HOLD, 8'h00, 0, 0, 0, 0);

        // Abort a transfer after its 4th shift edge, then run a clean one.
        step(MODE_HOLD, 8'hF0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(MODE_HOLD, 8'h00, 1, 0, 0, 0);
        chk("abort_busy_pre", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("abort_po", po, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(MODE_HOLD, 8'h00, 0, 0, 0, 0);
            chk("abort_no_done", done, 1'b0);
        end
        step(MODE_HOLD, 8'h3C, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(MODE_HOLD, 8'h00, 1, 0, 0, 0);
        chk("post_abort_po", po, 8'hFF);
        chk("post_abort_done", done, 1'b1);
        step(MODE_HOLD, 8'h00, 0, 0, 0, 0);
        step(MODE_HOLD, 8'h00, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
